// File: rtl/sample_framer_pkg.sv
// Shared constants and parameter checks for the transform front-end blocks.
// Imported by the framer and its testbench.
package sample_framer_pkg;

  localparam int FCNT_W = 16;

  function automatic bit params_ok(int n, int hop);
    return (n >= 2) && (n <= 64) && (hop >= 1) && (hop <= n);
  endfunction

endpackage

// File: rtl/sample_framer_if.sv
// Sample-in / frame-out handshake bundle for sample_framer.
// The framer itself sits on the slave side.
interface sample_framer_if #(
  parameter int DATA_W = 32,
  parameter int N      = 8
);

  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*DATA_W-1:0]   out_frame;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_frame
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_frame
  );

endinterface

// File: rtl/sample_framer_shift.sv
// Sample window: slot 0 holds the newest sample.
// The post-shift view is exported so a frame can capture it on the accept edge.
module sample_shift_reg #(
  parameter int DATA_W = 32,
  parameter int N      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DATA_W-1:0]   din,
  output logic [N*DATA_W-1:0] shifted
);

  logic [N*DATA_W-1:0] win;

  assign shifted = {win[(N-1)*DATA_W-1:0], din};

  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0;
    end else if (en) begin
      win <= shifted;
    end
  end

endmodule

// File: rtl/sample_framer.sv
// Sliding/blocked sample framer: collects N samples, emits a frame every HOP accepts.
// A pending frame stalls only the accept that would overwrite it.
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = 8,
  parameter int HOP    = 8
) (
  input  logic              clk,
  input  logic              rst,
  sample_framer_if.slave    bus,
  output logic [FCNT_W-1:0] frame_cnt
);

  if (!params_ok(N, HOP)) begin : g_bad_params
    $error("sample_framer: N must be 2..64 and HOP 1..N");
  end

  localparam int FILL_W = $clog2(N + 1);
  localparam int HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;

  logic [FILL_W-1:0]   fill;
  logic [HOP_W-1:0]    hop;
  logic                full;
  logic                completes;
  logic                accept;
  logic                load;
  logic                out_valid_q;
  logic [N*DATA_W-1:0] frame_q;
  logic [N*DATA_W-1:0] shifted;

  assign full      = (fill == FILL_W'(N));
  assign completes = full ? (hop == HOP_W'(HOP - 1))
                          : (fill == FILL_W'(N - 1));

  // Only the completing accept must wait for the downstream consumer.
  assign bus.in_ready = !(out_valid_q && !bus.out_ready && completes);

  assign accept = bus.in_valid && bus.in_ready;
  assign load   = accept && completes;

  assign bus.out_valid = out_valid_q;
  assign bus.out_frame = frame_q;

  sample_shift_reg #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_win (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .din     (bus.in_data),
    .shifted (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
      hop  <= '0;
    end else if (accept) begin
      if (!full) begin
        fill <= fill + FILL_W'(1);
      end else if (hop == HOP_W'(HOP - 1)) begin
        hop <= '0;
      end else begin
        hop <= hop + HOP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      frame_q     <= '0;
      frame_cnt   <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      frame_q     <= shifted;
      frame_cnt   <= frame_cnt + FCNT_W'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
